// File: rtl/disc_frame_sequencer.sv
// Frame collector and result returner around the 9-input MLP discriminator.
// Streams a frame in, holds it on a_flat, samples y after a settle delay.
module disc_frame_sequencer #(
    parameter int WIDTH         = 32,
    parameter int N_INPUT       = 9,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic [N_INPUT*WIDTH-1:0]   a_flat,
    input  logic [WIDTH-1:0]           y_in,
    input  logic [WIDTH-1:0]           threshold,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_score,
    output logic                       res_class,
    output logic                       err_frame,
    output logic [CNT_W-1:0]           frame_cnt
);

    localparam int IDX_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUT - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [3:0]                settle_cnt;
    logic [WIDTH-1:0]          shadow [N_INPUT];
    logic [N_INPUT*WIDTH-1:0]  frame_next;
    logic                      accept;
    logic                      is_final;
    logic                      y_ge_thr;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign is_final = (idx == LAST_IDX);
    assign y_ge_thr = ($signed(y_in) >= $signed(threshold));

    // The closing beat is still in flight, so it bypasses the shadow buffer.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N_INPUT; k++) begin
            frame_next[k*WIDTH +: WIDTH] = shadow[k];
        end
        frame_next[(N_INPUT-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= '0;
            settle_cnt <= '0;
            a_flat     <= '0;
            res_valid  <= 1'b0;
            res_score  <= '0;
            res_class  <= 1'b0;
            err_frame  <= 1'b0;
            frame_cnt  <= '0;
            for (int k = 0; k < N_INPUT; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            err_frame <= 1'b0;
            unique case (state)
                FILL: begin
                    if (accept) begin
                        shadow[idx] <= in_data;
                        if (is_final) begin
                            a_flat     <= frame_next;
                            idx        <= '0;
                            settle_cnt <= SETTLE_INIT;
                            state      <= SETTLE;
                            err_frame  <= !in_last;
                        end else if (in_last) begin
                            idx       <= '0;
                            err_frame <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        res_score <= y_in;
                        res_class <= y_ge_thr;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: doc/disc_frame_sequencer.md
Name: disc_frame_sequencer

Overview:
Sequential front/back wrapper for the 9-input, 3-2-1 MLP discriminator. It collects a 9-word signed sample frame over a valid/ready stream into a shadow buffer, then presents all nine words in parallel and holds them stable. After a programmable settle time it captures the discriminator's combinational output y, thresholds it, and returns score plus class over a valid/ready result handshake. It sits directly upstream of the discriminator's a_1..a_9 inputs and directly downstream of its y output.

Parameters:
WIDTH, 32, data word width (signed, same fixed-point format as discriminator)
N_INPUT, 9, words per frame (discriminator fan-in)
SETTLE_CYCLES, 2, cycles between applying a_flat and capturing y; legal range 1..15
CNT_W, 16, width of frame counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample word valid
in_ready  out  1  sequencer accepts sample word
in_data  in  WIDTH  signed sample word
in_last  in  1  marks final word of frame
a_flat  out  N_INPUT*WIDTH  parallel frame to discriminator; a_k = a_flat[(k-1)*WIDTH +: WIDTH], k=1..9
y_in  in  WIDTH  signed discriminator output y
threshold  in  WIDTH  signed decision threshold, sampled when y is captured
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_score  out  WIDTH  captured y
res_class  out  1  1 when captured y >= threshold (signed compare)
err_frame  out  1  one-cycle pulse on framing error
frame_cnt  out  CNT_W  count of results delivered, wraps at 2^CNT_W

Behaviour:
- Reset (rst_n=0, async): state=FILL, word index=0, shadow buffer=0, a_flat=0, res_valid=0, res_score=0, res_class=0, err_frame=0, frame_cnt=0, settle counter=0.
- States: FILL, SETTLE, HOLD.
- in_ready = (state==FILL), combinational from the state register. A beat is accepted when in_valid && in_ready.
- FILL: each accepted beat writes shadow[idx]=in_data and increments idx. Word 0 maps to a_1.
  - Beat with idx==N_INPUT-1: copy the full shadow buffer, including this beat's in_data, into a_flat on the same edge. Set idx=0, settle counter=SETTLE_CYCLES-1, state=SETTLE.
  - If in_last is 0 on that beat, the frame is still accepted and err_frame pulses.
  - Beat with in_last=1 and idx<N_INPUT-1: drop the frame, set idx=0, pulse err_frame, stay in FILL. a_flat is unchanged.
- a_flat changes only on the FILL->SETTLE edge. It stays stable through SETTLE and HOLD, so the discriminator sees one clean input transition per frame.
- SETTLE: settle counter decrements each cycle.
  - On the cycle the counter equals 0, the edge captures res_score=y_in and res_class=($signed(y_in) >= $signed(threshold)), sets res_valid=1 and moves to HOLD.
  - Latency: last input beat at edge k gives res_valid high from edge k+SETTLE_CYCLES.
- HOLD: res_valid=1. res_score and res_class are held until res_valid && res_ready.
  - On that edge: res_valid=0, frame_cnt+=1 (modulo 2^CNT_W), state=FILL.
  - in_ready returns high the following cycle, a one-cycle bubble by design.
  - res_ready=1 while res_valid=0 has no effect.
- in_valid while in_ready=0 (SETTLE/HOLD) is ignored. The upstream source must hold the beat.
- Threshold equality counts as class 1. Both operands are compared as full-width signed values with no truncation.
- Reset asserted mid-frame or mid-HOLD aborts everything immediately. The partial frame and any pending result are discarded, and no err_frame pulse is generated.
- err_frame is registered and is high for exactly one cycle per error.

Test Plan:
1. Reset, then stream words 1..9 (in_last on word 9) with no stalls, y_in tied to a_1+a_9, threshold=5 -> a_flat words 1..9 in order. res_valid rises exactly SETTLE_CYCLES=2 edges after beat 9 with res_score=10, res_class=1, frame_cnt=1 after handshake.
2. Same frame with y_in=-3, threshold=-3, then y_in=-4 -> res_class=1 for the first (equality), 0 for the second. Check signed compare with y_in=32'h8000_0000, threshold=0 -> res_class=0.
3. in_last asserted on word 5 -> err_frame single pulse, no res_valid. The next clean 9-word frame produces a correct result, and a_flat is unchanged until that frame completes.
4. 9 words with no in_last -> err_frame pulse AND result delivered normally.
5. Hold res_ready=0 for 20 cycles while in_valid=1 -> in_ready=0, res_score/res_class/a_flat stable, no beats accepted. On release: one-cycle bubble, then the next frame is accepted from word 0.
6. Assert rst_n=0 after word 4 and again during HOLD -> all outputs return to reset values asynchronously (before the next clk edge), and no result or err_frame appears. Also run frame_cnt wrap with CNT_W=2 over 5 frames -> 1,2,3,0,1.
